// File: rtl/vco_phase_quantizer_diff.sv
// Differential ring-VCO phase quantizer: two identical lanes turn raw tap snapshots
// into per-cycle phase increments. Optional `VCO_BUBBLE_FILTER_EN` adds ring-majority bubble repair.

module vco_pq_lane #(
    parameter int BW = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_emit,
    input  logic [2**BW-1:0] i_taps,
    output logic [BW:0]      o_out
);
    localparam int PHASES = 2**BW;

    logic [PHASES-1:0] r_s1;
    logic [PHASES-1:0] r_s2;
    logic [BW:0]       r_dec;
    logic [BW:0]       r_prev;
    logic [BW:0]       r_out;
    logic [PHASES-1:0] w_bits;
    logic [BW:0]       w_cnt;
    logic [BW:0]       w_phase;

`ifdef VCO_BUBBLE_FILTER_EN
    // Ring extension: neighbours beyond either end are the inverted opposite end.
    logic [PHASES+1:0] w_ext;
    assign w_ext = {~r_s2[0], r_s2, ~r_s2[PHASES-1]};

    always_comb begin
        w_bits = '0;
        for (int i = 0; i < PHASES; i++) begin
            w_bits[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) | (w_ext[i+1] & w_ext[i+2]);
        end
    end
`else
    assign w_bits = r_s2;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < PHASES; i++) begin
            w_cnt = w_cnt + (BW+1)'(w_bits[i]);
        end
        w_phase = w_bits[0] ? w_cnt : (BW+1)'(0) - w_cnt;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_dec <= '0;
        end else begin
            r_s1  <= i_taps;
            r_s2  <= r_s1;
            r_dec <= w_phase;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
            r_out  <= '0;
        end else if (!i_enable) begin
            r_prev <= '0;
            r_out  <= '0;
        end else begin
            r_prev <= r_dec;
            if (i_emit) begin
                r_out <= r_dec - r_prev;
            end
        end
    end

    assign o_out = r_out;
endmodule

module vco_phase_quantizer_diff #(
    parameter int BW = 5
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             ENABLE,
    input  logic [2**BW-1:0] PH_p,
    input  logic [2**BW-1:0] PH_m,
    output logic [BW:0]      OUT_p,
    output logic [BW:0]      OUT_m,
    output logic             VALID
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_emit;
    logic   r_valid;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!ENABLE) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_PRIME;
                ST_PRIME: w_next = ST_RUN;
                ST_RUN:   w_next = ST_RUN;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // The first enabled edge only primes PREV; differences are emitted from then on.
    always_comb begin
        w_emit = ENABLE && (r_state != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_emit;
        end
    end

    vco_pq_lane #(.BW(BW)) u_lane_p (
        .i_clk    (CLK),
        .i_rst_n  (RES),
        .i_enable (ENABLE),
        .i_emit   (w_emit),
        .i_taps   (PH_p),
        .o_out    (OUT_p)
    );

    vco_pq_lane #(.BW(BW)) u_lane_m (
        .i_clk    (CLK),
        .i_rst_n  (RES),
        .i_enable (ENABLE),
        .i_emit   (w_emit),
        .i_taps   (PH_m),
        .o_out    (OUT_m)
    );

    assign VALID = r_valid;
endmodule

// File: tb/tb_vco_phase_quantizer_diff.sv
// Randomized self-checking bench for vco_phase_quantizer_diff (BW=5, 32 taps) against a
// snapshot-history reference model; honours `VCO_BUBBLE_FILTER_EN` when defined.

module tb_vco_phase_quantizer_diff;
    localparam int BW     = 5;
    localparam int PHASES = 32;
    localparam int HMAX   = 1024;

    logic        CLK = 1'b0;
    logic        RES;
    logic        ENABLE;
    logic [31:0] PH_p;
    logic [31:0] PH_m;
    logic [5:0]  OUT_p;
    logic [5:0]  OUT_m;
    logic        VALID;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] h_p  [HMAX];
    logic [31:0] h_m  [HMAX];
    bit          h_en [HMAX];
    int          e;

    vco_phase_quantizer_diff #(.BW(BW)) dut (
        .CLK    (CLK),
        .RES    (RES),
        .ENABLE (ENABLE),
        .PH_p   (PH_p),
        .PH_m   (PH_m),
        .OUT_p  (OUT_p),
        .OUT_m  (OUT_m),
        .VALID  (VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Thermometer snapshot of ring state k (0..63).
    function automatic logic [31:0] therm(input int k);
        logic [31:0] s;
        for (int i = 0; i < PHASES; i++) begin
            s[i] = (k <= PHASES) ? (i < k) : (i >= k - PHASES);
        end
        return s;
    endfunction

    // Phase of a tap snapshot from the decode rules: ones count, mirrored when tap 0 is low.
    function automatic int dec(input logic [31:0] s);
        logic [31:0] b;
        int          c;
        b = s;
`ifdef VCO_BUBBLE_FILTER_EN
        for (int i = 0; i < PHASES; i++) begin
            int l, r, v;
            l = (i == 0) ? int'(~s[PHASES-1]) : int'(s[i-1]);
            r = (i == PHASES - 1) ? int'(~s[0]) : int'(s[i+1]);
            v = l + int'(s[i]) + r;
            b[i] = (v >= 2);
        end
`endif
        c = 0;
        for (int i = 0; i < PHASES; i++) c += int'(b[i]);
        return b[0] ? c : (2 * PHASES - c) % (2 * PHASES);
    endfunction

    function automatic logic [31:0] snap_p(input int i);
        return (i < 0) ? 32'd0 : h_p[i];
    endfunction

    function automatic logic [31:0] snap_m(input int i);
        return (i < 0) ? 32'd0 : h_m[i];
    endfunction

    function automatic bit en_at(input int i);
        return (i < 0) ? 1'b0 : h_en[i];
    endfunction

    task automatic clear_history();
        for (int i = 0; i < HMAX; i++) begin
            h_p[i] = '0; h_m[i] = '0; h_en[i] = 1'b0;
        end
        e = 0;
    endtask

    // One clock edge; expected outputs follow from snapshots and enables seen at each edge.
    task automatic step();
        bit exp_v;
        int exp_p, exp_m;
        h_p[e]  = PH_p;
        h_m[e]  = PH_m;
        h_en[e] = ENABLE;
        @(posedge CLK);
        #1;
        exp_v = en_at(e) && en_at(e - 1);
        exp_p = exp_v ? ((dec(snap_p(e - 3)) - dec(snap_p(e - 4)) + 64) % 64) : 0;
        exp_m = exp_v ? ((dec(snap_m(e - 3)) - dec(snap_m(e - 4)) + 64) % 64) : 0;
        check("valid", 32'(VALID), 32'(exp_v));
        check("out_p", 32'(OUT_p), 32'(exp_p));
        check("out_m", 32'(OUT_m), 32'(exp_m));
        if (e < HMAX - 1) e++;
    endtask

    task automatic drive(input int kp, input int km);
        PH_p = therm(kp);
        PH_m = therm(km);
    endtask

    int          sp, sm;
    bit          seen;
    logic [31:0] bub;
    logic [31:0] captured;

    initial begin
        RES = 1'b0; ENABLE = 1'b0; PH_p = '0; PH_m = '0;
        clear_history();
        #3;
        check("rst_valid", 32'(VALID), 0);
        check("rst_out_p", 32'(OUT_p), 0);
        check("rst_out_m", 32'(OUT_m), 0);
        @(negedge CLK);
        RES = 1'b1;
        repeat (3) step();

        // Ramp +5 on the positive side across the 63->0 wrap; negative side static.
        ENABLE = 1'b1;
        sp = 0; sm = 20;
        for (int i = 0; i < 40; i++) begin
            drive(sp, sm);
            step();
            if (i >= 5) check("ramp5", 32'(OUT_p), 5);
            sp = (sp + 5) % 64;
        end

        // Differential +7 / +3.
        for (int i = 0; i < 30; i++) begin
            drive(sp, sm);
            step();
            if (i >= 4) check("diff_pm", 32'((OUT_p - OUT_m) & 6'h3f), 4);
            sp = (sp + 7) % 64;
            sm = (sm + 3) % 64;
        end

        // One-cycle enable drop mid-run.
        ENABLE = 1'b0;
        drive(sp, sm);
        step();
        sp = (sp + 7) % 64; sm = (sm + 3) % 64;
        ENABLE = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(sp, sm);
            step();
            if (VALID && !seen) begin
                seen = 1'b1;
                check("reen_gap", 32'(i), 1);
                check("reen_first", 32'(OUT_p), 7);
            end
            sp = (sp + 7) % 64; sm = (sm + 3) % 64;
        end
        if (!seen) check("reen_seen", 0, 1);

        // Static snapshot on both sides.
        for (int i = 0; i < 8; i++) begin
            drive(41, 41);
            step();
        end
        check("static_p", 32'(OUT_p), 0);
        check("static_m", 32'(OUT_m), 0);

        // Bubble: state 10 with tap 4 dropped, entered from state 0.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0);
            step();
        end
        bub = therm(10);
        bub[4] = 1'b0;
        captured = '0;
        for (int i = 0; i < 6; i++) begin
            PH_p = bub;
            PH_m = '0;
            step();
            if (VALID && OUT_p != 0 && captured == 0) captured = 32'(OUT_p);
        end
`ifdef VCO_BUBBLE_FILTER_EN
        check("bubble", captured, 10);
`else
        check("bubble", captured, 9);
`endif

        // Random states with occasional enable drops.
        for (int i = 0; i < 150; i++) begin
            ENABLE = ($urandom_range(0, 9) != 0);
            drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            step();
        end

        // Asynchronous reset in the middle of RUN.
        ENABLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            step();
        end
        #2;
        RES = 1'b0;
        #1;
        check("arst_valid", 32'(VALID), 0);
        check("arst_out_p", 32'(OUT_p), 0);
        check("arst_out_m", 32'(OUT_m), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        clear_history();
        RES = 1'b1;
        sp = 3; sm = 50;
        for (int i = 0; i < 10; i++) begin
            drive(sp, sm);
            step();
            if (i == 0) check("rel_valid1", 32'(VALID), 0);
            if (i == 1) check("rel_valid2", 32'(VALID), 1);
            sp = (sp + 5) % 64; sm = (sm + 2) % 64;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
